// File: rtl/player_motion_controller.sv
// player_motion_controller
//
// Steps a player/head position across a tile grid, one tile per game_en tick.
// Direction requests are latched between ticks into a pending direction, direct
// reversals of the current heading are rejected, and a step that would leave
// the playfield halts the controller until restart.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   game_en     one-cycle step tick
//   btn_up/down/left/right  direction requests (priority up > down > left > right)
//   restart     leaves HALT back to IDLE at the start position
//   pos_x/pos_y current tile (registered)
//   dir         current heading: 00 right, 01 left, 10 up, 11 down
//   running     high while in RUN
//   step_pulse  one-cycle pulse after each completed step
//   wall_hit    one-cycle pulse when a step is blocked by a wall

module player_motion_controller #(
    parameter int unsigned X_MAX   = 39,
    parameter int unsigned Y_MAX   = 29,
    parameter int unsigned X_START = 20,
    parameter int unsigned Y_START = 15,
    parameter int unsigned XW      = 6,
    parameter int unsigned YW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          game_en,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          restart,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [1:0]    dir,
    output logic          running,
    output logic          step_pulse,
    output logic          wall_hit
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    localparam logic [1:0] DirRight = 2'b00;
    localparam logic [1:0] DirLeft  = 2'b01;
    localparam logic [1:0] DirUp    = 2'b10;
    localparam logic [1:0] DirDown  = 2'b11;

    localparam logic [XW:0]   XLim   = (XW+1)'(X_MAX);
    localparam logic [YW:0]   YLim   = (YW+1)'(Y_MAX);
    localparam logic [XW-1:0] XStart = XW'(X_START);
    localparam logic [YW-1:0] YStart = YW'(Y_START);

    state_e        state_q, state_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    pend_q, pend_d;
    logic          running_q, running_d;
    logic          step_pulse_q, step_pulse_d;
    logic          wall_hit_q, wall_hit_d;

    logic          btn_any;
    logic [1:0]    btn_dir;
    logic [XW:0]   next_x;
    logic [YW:0]   next_y;
    logic          step_ok;

    // Priority-resolve the buttons into a single request.
    always_comb begin
        btn_any = btn_up | btn_down | btn_left | btn_right;
        if (btn_up) begin
            btn_dir = DirUp;
        end else if (btn_down) begin
            btn_dir = DirDown;
        end else if (btn_left) begin
            btn_dir = DirLeft;
        end else begin
            btn_dir = DirRight;
        end
    end

    // Target tile for the pending direction, one bit wider so that 0 - 1
    // lands above the limit instead of wrapping to a valid coordinate.
    always_comb begin
        next_x = {1'b0, pos_x_q};
        next_y = {1'b0, pos_y_q};
        unique case (pend_q)
            DirRight: next_x = {1'b0, pos_x_q} + (XW+1)'(1);
            DirLeft:  next_x = {1'b0, pos_x_q} - (XW+1)'(1);
            DirUp:    next_y = {1'b0, pos_y_q} - (YW+1)'(1);
            DirDown:  next_y = {1'b0, pos_y_q} + (YW+1)'(1);
        endcase
        step_ok = (next_x <= XLim) && (next_y <= YLim);
    end

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        step_pulse_d = 1'b0;
        wall_hit_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (btn_any) begin
                    dir_d   = btn_dir;
                    pend_d  = btn_dir;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Reversal check is against the heading before this edge's step;
                // dir ^ 01 flips right<->left and up<->down.
                if (btn_any && (btn_dir != (dir_q ^ 2'b01))) begin
                    pend_d = btn_dir;
                end
                if (game_en) begin
                    dir_d = pend_q;
                    if (step_ok) begin
                        pos_x_d      = next_x[XW-1:0];
                        pos_y_d      = next_y[YW-1:0];
                        step_pulse_d = 1'b1;
                    end else begin
                        wall_hit_d = 1'b1;
                        state_d    = StHalt;
                    end
                end
            end
            StHalt: begin
                if (restart) begin
                    pos_x_d = XStart;
                    pos_y_d = YStart;
                    dir_d   = DirRight;
                    pend_d  = DirRight;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pos_x_q      <= XStart;
            pos_y_q      <= YStart;
            dir_q        <= DirRight;
            pend_q       <= DirRight;
            running_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            wall_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            running_q    <= running_d;
            step_pulse_q <= step_pulse_d;
            wall_hit_q   <= wall_hit_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign dir        = dir_q;
    assign running    = running_q;
    assign step_pulse = step_pulse_q;
    assign wall_hit   = wall_hit_q;

endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: directed scenarios followed by random
// stimulus, every cycle compared against a tile-level behavioural model.

module tb_player_motion_controller;

    localparam int XM = 39;
    localparam int YM = 29;
    localparam int XS = 20;
    localparam int YS = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_en = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       restart = 1'b0;
    logic [5:0] pos_x;
    logic [4:0] pos_y;
    logic [1:0] dir;
    logic       running, step_pulse, wall_hit;

    player_motion_controller dut (
        .clk        (clk),
        .rst        (rst),
        .game_en    (game_en),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .restart    (restart),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .dir        (dir),
        .running    (running),
        .step_pulse (step_pulse),
        .wall_hit   (wall_hit)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 run, 2 halt; directions 0 right, 1 left, 2 up, 3 down.
    int m_x, m_y, m_dir, m_pend, m_mode;
    int m_step, m_wall;
    int dxs[4] = '{1, -1, 0, 0};
    int dys[4] = '{0, 0, -1, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic m_reset();
        m_x = XS; m_y = YS; m_dir = 0; m_pend = 0; m_mode = 0;
        m_step = 0; m_wall = 0;
    endtask

    // One rising edge with rst released, using the currently driven inputs.
    task automatic m_edge();
        int any, req, old_pend, tx, ty;
        any = int'(btn_up | btn_down | btn_left | btn_right);
        req = btn_up ? 2 : btn_down ? 3 : btn_left ? 1 : 0;
        m_step = 0;
        m_wall = 0;
        case (m_mode)
            0: if (any != 0) begin
                m_dir = req; m_pend = req; m_mode = 1;
            end
            1: begin
                old_pend = m_pend;
                if (any != 0 && req != opposite(m_dir)) m_pend = req;
                if (game_en) begin
                    m_dir = old_pend;
                    tx = m_x + dxs[old_pend];
                    ty = m_y + dys[old_pend];
                    if (tx >= 0 && tx <= XM && ty >= 0 && ty <= YM) begin
                        m_x = tx; m_y = ty; m_step = 1;
                    end else begin
                        m_wall = 1; m_mode = 2;
                    end
                end
            end
            default: if (restart) begin
                m_x = XS; m_y = YS; m_dir = 0; m_pend = 0; m_mode = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pos_x"}, 32'(pos_x), m_x);
        check({tag, ".pos_y"}, 32'(pos_y), m_y);
        check({tag, ".dir"}, 32'(dir), m_dir);
        check({tag, ".running"}, 32'(running), (m_mode == 1) ? 1 : 0);
        check({tag, ".step_pulse"}, 32'(step_pulse), m_step);
        check({tag, ".wall_hit"}, 32'(wall_hit), m_wall);
    endtask

    // Called at a falling edge; drives inputs, clocks once, checks, returns at
    // the next falling edge.
    task automatic cyc(input string tag, input bit ge, input bit u, input bit d,
                       input bit l, input bit r, input bit rs);
        game_en = ge; btn_up = u; btn_down = d; btn_left = l; btn_right = r; restart = rs;
        @(posedge clk);
        m_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic tick(input string tag);
        cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset at a falling edge (optionally alongside game_en), holds it
    // across one rising edge, releases it at the next falling edge.
    task automatic do_reset(input bit ge);
        rst = 1'b0; game_en = ge;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; restart = 1'b0;
        #1;
        m_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b1; game_en = 1'b0;
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        do_reset(1'b0);
        check("reset_x", 32'(pos_x), XS);
        check("reset_y", 32'(pos_y), YS);

        // Start right, three steps.
        cyc("start_r", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick("step_r");
            check("step_r_x", 32'(pos_x), 32'(XS + 1 + i));
            check("step_r_pulse", 32'(step_pulse), 1);
        end
        check("running", 32'(running), 1);

        // Reversal rejected, then a legal turn up.
        cyc("rev_btn", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("rev_tick");
        check("rev_x", 32'(pos_x), 24);
        check("rev_dir", 32'(dir), 0);
        cyc("up_btn", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("up_tick");
        check("up_dir", 32'(dir), 2);
        check("up_y", 32'(pos_y), 14);

        // Run up into the top wall from the start tile.
        do_reset(1'b0);
        cyc("go_up", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick("climb");
        check("top_y", 32'(pos_y), 0);
        tick("wall");
        check("wall_y", 32'(pos_y), 0);
        check("wall_pulse", 32'(wall_hit), 1);
        check("wall_running", 32'(running), 0);
        tick("halt_tick");
        check("wall_once", 32'(wall_hit), 0);
        cyc("halt_btn", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("restart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_x", 32'(pos_x), XS);
        check("restart_y", 32'(pos_y), YS);
        tick("idle_tick");
        check("idle_no_step", 32'(step_pulse), 0);

        // Priority up over right, then down on a tick edge is rejected.
        cyc("prio", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("prio_dir", 32'(dir), 2);
        check("prio_no_step", 32'(pos_y), YS);
        cyc("down_on_tick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("dot_y", 32'(pos_y), 14);
        tick("after_dot");
        check("after_dot_y", 32'(pos_y), 13);

        // Reset on the same edge as a tick.
        do_reset(1'b1);
        check("rst_tick_pulse", 32'(step_pulse), 0);
        check("rst_tick_run", 32'(running), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cyc("rand",
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_motion_controller.md
# player_motion_controller

Consumes the periodic one-cycle `game_en` tick from the game clock generator and advances a player/head position on a tile grid, one step per tick. It latches direction requests from the buttons between ticks, rejects direct reversals, clamps at the playfield walls, and halts on a wall hit until restarted. Its registered position and status outputs feed the VGA renderer and the game-logic blocks.

## Interface
Parameters:
- `X_MAX`, default 39: last valid column; the grid spans 0..X_MAX.
- `Y_MAX`, default 29: last valid row; the grid spans 0..Y_MAX.
- `X_START`, default 20: column after reset or restart.
- `Y_START`, default 15: row after reset or restart.
- `XW`, default 6: width of `pos_x`.
- `YW`, default 5: width of `pos_y`.

Ports:
- `clk`, in, 1: 50 MHz system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `game_en`, in, 1: one-cycle step tick.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: direction requests, active-high levels, already synchronized and debounced.
- `restart`, in, 1: active-high; acted on only in HALT.
- `pos_x`, out, XW: current column.
- `pos_y`, out, YW: current row (0 = top).
- `dir`, out, 2: current direction. 00 = right, 01 = left, 10 = up, 11 = down.
- `running`, out, 1: high while in RUN.
- `step_pulse`, out, 1: one-cycle pulse after each completed step.
- `wall_hit`, out, 1: one-cycle pulse when a step is blocked by a wall.

## Operation
- States: IDLE, RUN, HALT.
- Reset (`rst` = 0): state IDLE, `pos_x` = X_START, `pos_y` = Y_START, `dir` = 00, pending direction = 00, `running`/`step_pulse`/`wall_hit` = 0.
- Button priority when several are high: up > down > left > right. One resolved request per clock.
- IDLE:
  - `game_en` is ignored.
  - Any button high: pending direction and `dir` take the resolved direction; go to RUN. No reversal check in IDLE.
- RUN, direction requests:
  - A request sets pending direction unless it is the opposite of `dir`. Opposite pairs are right/left and up/down.
  - A rejected request leaves pending direction unchanged.
  - The reversal check is against `dir`, not against pending direction.
- RUN, on `game_en` = 1:
  - `dir` takes pending direction.
  - Right: x + 1. Left: x − 1. Up: y − 1. Down: y + 1.
  - If the target is inside 0..X_MAX / 0..Y_MAX: update the position and pulse `step_pulse`.
  - Otherwise: hold the position (no wrap, no underflow), pulse `wall_hit`, go to HALT. `step_pulse` stays 0.
- HALT:
  - `game_en` and buttons are ignored.
  - `restart` = 1: position = (X_START, Y_START), `dir` = 00, pending direction = 00, go to IDLE.
- `restart` in IDLE or RUN has no effect.
- Arithmetic: bound checks are done one bit wider than XW/YW. The 0 − 1 case is detected as a wall hit, never as a wrap to the maximum.

## Timing
- All outputs are registered.
- A `game_en` sampled at edge N gives the new `pos_x`/`pos_y`/`dir` and the `step_pulse` or `wall_hit` pulse visible after edge N. Each pulse lasts exactly one cycle.
- `running` goes high the cycle after the IDLE→RUN button edge and low the cycle after the wall-hit edge.
- A button sampled on the same edge as `game_en`:
  - does not affect that step;
  - updates pending direction, checked against the pre-step `dir`;
  - takes effect at the next tick.
- Button and `game_en` on the same edge in IDLE: the transition to RUN happens; no step occurs.
- Back-to-back `game_en` on consecutive cycles: each one is a full step (no internal rate limiting).
- Reset mid-operation: all registers return to reset values immediately, asynchronously. There is no pending step after reset is released.

## Test plan
- Reset, `btn_right` for 1 cycle, then 3 `game_en` ticks → `pos_x` 21, 22, 23; `pos_y` 15; 3 `step_pulse`; `running` = 1.
- In RUN moving right, press `btn_left`, then tick → reversal rejected, `pos_x` +1, `dir` stays 00. Press `btn_up`, then tick → `dir` = 10, `pos_y` 15→14.
- From (20,15) moving up, 15 ticks reach `pos_y` = 0. A 16th tick → `pos_y` stays 0, `wall_hit` for 1 cycle, `running` = 0. Further ticks → no change.
- In HALT, pulse `restart` → (20,15), `dir` 00, IDLE. A tick with no button → no step.
- `btn_up` and `btn_right` both high in IDLE → `dir` = 10. `btn_down` on the same edge as `game_en` → that step still goes up; the next step is also up, because down is rejected as a reversal of up.
- Assert `rst` = 0 on the same edge as a `game_en` in RUN → outputs return to reset values; no `step_pulse`.
